mux2to1_arbiter: RTL
====================

MUX2TO1_ARBITER -- requirements
Module: mux2to1_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width of each requester and of the output.
REQ-002 Parameter BURST, default 4, SHALL set the maximum consecutive beats granted to one requester when MUX2_ARB_BURST_EN is defined; legal range 1-15.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 in0_valid  input  1  SHALL indicate requester 0 offers in0_data.
REQ-006 in0_data  input  WIDTH  SHALL carry requester 0 payload.
REQ-007 in0_ready  output  1  SHALL indicate requester 0 beat is accepted this cycle.
REQ-008 in1_valid / in1_data / in1_ready  input / input / output  1 / WIDTH / 1  SHALL mirror REQ-005 to REQ-007 for requester 1.
REQ-009 sel  output  1  SHALL drive the shared 2:1 mux select; 0 = in0, 1 = in1.
REQ-010 out_valid  output  1  SHALL indicate out_data holds a registered beat.
REQ-011 out_data  output  WIDTH  SHALL hold the registered mux output.
REQ-012 out_ready  input  1  SHALL indicate the consumer accepts out_data this cycle.

Function
REQ-013 Load enable ld SHALL be (!out_valid || out_ready), computed combinationally.
REQ-014 State SHALL be a 3-state FSM: IDLE (nothing served yet or since the last idle cycle), LAST0 (last accepted beat came from in0), LAST1 (last accepted beat came from in1).
REQ-015 Selection: one valid -> sel picks it; both valid -> sel picks the requester not recorded as last (IDLE counts as LAST1, so in0 wins); none valid -> sel holds its previous value.
REQ-016 inN_ready SHALL be ld && (sel == N) && inN_valid; at most one ready high per cycle.
REQ-017 On an accept, out_data <= selected data and out_valid <= 1 on the next edge: one-cycle latency, no combinational path from inN_data to out_data.
REQ-018 If ld is high and no input is valid, out_valid <= 0 and the FSM goes to IDLE.
REQ-019 Back-to-back: out_ready high and a new accept in the same cycle SHALL sustain one beat per cycle with no bubble.
REQ-020 Stall: while out_valid && !out_ready, out_data, out_valid, the FSM state and the burst counter SHALL hold, and both readies SHALL be 0.
REQ-021 Requester data SHALL be captured only in a cycle where its ready is high; inN_valid is not required to remain stable while unaccepted.
REQ-022 Round-robin fairness: with both requesters continuously valid and out_ready tied high (macro undefined), grants SHALL alternate 0,1,0,1...

Reset
REQ-023 While rst is high at a clock edge: out_valid <= 0, out_data <= 0, FSM <= IDLE, sel <= 0, burst counter <= 0.
REQ-024 Both inN_ready SHALL be 0 in every cycle rst is high; a reset mid-stream SHALL discard the registered beat without presenting it.

Configuration
REQ-025 Macro MUX2_ARB_BURST_EN, when defined, SHALL add a 4-bit burst counter that increments on each accept from the same requester and clears on a switch or when entering IDLE.
REQ-026 With MUX2_ARB_BURST_EN defined, if the last-served requester is still valid and the counter is below BURST-1, it SHALL keep the grant even when the other requester is valid; on reaching BURST-1 the grant SHALL pass to the other requester if it is valid.
REQ-027 With MUX2_ARB_BURST_EN undefined, the counter SHALL not exist and selection SHALL follow REQ-015 strictly.

Verification (WIDTH=8, BURST=4)
REQ-028 Reset: rst=1 for 2 cycles with both valid -> out_valid=0, out_data=8'h00, in0_ready=in1_ready=0, sel=0.
REQ-029 Single requester: in0_valid=1, in0_data=8'hA5, out_ready=1 -> in0_ready=1 the same cycle, and out_valid=1 with out_data=8'hA5 one cycle later.
REQ-030 Contention (macro undefined): in0_data=8'h11, in1_data=8'h22, both valid, out_ready=1 for 4 cycles -> out_data sequence 11,22,11,22.
REQ-031 Burst (macro defined): both valid for 8 cycles, out_ready=1 -> sel sequence 0,0,0,0,1,1,1,1.
REQ-032 Stall: out_valid=1 with out_data=8'h33, out_ready=0 for 3 cycles -> out_data stays 8'h33 and both readies stay 0; out_ready=1 -> the next beat is accepted that same cycle.
REQ-033 Reset mid-stream: rst=1 while out_valid=1 -> out_valid=0 on the next edge, and after release in0 wins the first contention.

Source files
------------

// File: rtl/mux2to1_arbiter.sv
// Two-requester round-robin arbiter that drives a shared 2:1 mux into a one-deep registered output stage.
// Define MUX2_ARB_BURST_EN to let a requester hold the grant for up to BURST consecutive beats.
//
// state    | meaning
// ---------+----------------------------------------------------
// ST_IDLE  | nothing served yet, or an idle load cycle occurred
// ST_LAST0 | last accepted beat came from in0
// ST_LAST1 | last accepted beat came from in1

module mux2to1_arbiter #(
   parameter int WIDTH = 8,
   parameter int BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in0_valid,
   input  logic [WIDTH-1:0] in0_data,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   output logic             in1_ready,
   output logic             sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LAST0 = 2'd1;
   localparam logic [1:0] ST_LAST1 = 2'd2;

   if (BURST < 1 || BURST > 15) begin : g_burst_range
      $error("mux2to1_arbiter: BURST must be in 1..15");
   end

   logic [1:0]       r_state;
   logic             r_sel;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;

   logic             w_ld;
   logic             w_sel;
   logic             w_pick_both;
   logic             w_accept;
   logic [1:0]       w_next_last;
   logic [WIDTH-1:0] w_data;

`ifdef MUX2_ARB_BURST_EN
   localparam logic [3:0] BURST_LAST = 4'(BURST - 1);

   logic [3:0] r_burst_cnt;
   logic       w_keep;

   assign w_keep = (r_burst_cnt < BURST_LAST);

   always_comb begin
      w_pick_both = 1'b0;
      case (r_state)
         ST_LAST0: w_pick_both = !w_keep;
         ST_LAST1: w_pick_both = w_keep;
         default:  w_pick_both = 1'b0;
      endcase
   end

   // Counts repeat grants to the same requester; cleared on a switch or idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_burst_cnt <= 4'd0;
      end else if (w_ld) begin
         if (w_accept && (r_state == w_next_last)) begin
            if (r_burst_cnt != 4'hF) begin
               r_burst_cnt <= r_burst_cnt + 4'd1;
            end
         end else begin
            r_burst_cnt <= 4'd0;
         end
      end
   end
`else
   // Plain alternation: IDLE behaves like LAST1 so in0 wins the first contention.
   always_comb begin
      w_pick_both = (r_state == ST_LAST0);
   end
`endif

   assign w_ld = !r_out_valid || out_ready;

   always_comb begin
      w_sel = r_sel;
      if (rst) begin
         w_sel = 1'b0;
      end else if (in0_valid && in1_valid) begin
         w_sel = w_pick_both;
      end else if (in0_valid) begin
         w_sel = 1'b0;
      end else if (in1_valid) begin
         w_sel = 1'b1;
      end
   end

   assign in0_ready   = !rst && w_ld && !w_sel && in0_valid;
   assign in1_ready   = !rst && w_ld &&  w_sel && in1_valid;
   assign w_accept    = in0_ready || in1_ready;
   assign w_next_last = w_sel ? ST_LAST1 : ST_LAST0;
   assign w_data      = w_sel ? in1_data : in0_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_sel       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_sel <= w_sel;
         if (w_ld) begin
            if (w_accept) begin
               r_out_valid <= 1'b1;
               r_out_data  <= w_data;
               r_state     <= w_next_last;
            end else begin
               r_out_valid <= 1'b0;
               r_state     <= ST_IDLE;
            end
         end
      end
   end

   assign sel       = w_sel;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

endmodule
